// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit with return-address stack.
package fetch_pkg;

  localparam int ADDR_W_DEFAULT = 16;
  localparam int TGT_W_DEFAULT  = 8;

  // Source of the next program counter value.
  typedef enum logic [1:0] {
    SEL_INC = 2'd0,
    SEL_TGT = 2'd1,
    SEL_RET = 2'd2
  } next_pc_sel_t;

  // Sign-extend the low 'w' bits of 'v' to 32 bits (1 <= w <= 31).
  function automatic logic [31:0] sext_tgt(input logic [31:0] v, input int unsigned w);
    logic [31:0] hi_mask;
    hi_mask = 32'hFFFF_FFFF << w;
    if (v[w-1]) begin
      sext_tgt = v | hi_mask;
    end else begin
      sext_tgt = v & ~hi_mask;
    end
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular-buffer return-address stack. A push while full overwrites the
// oldest entry; a pop while empty is ignored. Both cases set sticky flags.
module return_addr_stack
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEFAULT,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_data,
  output logic [ADDR_W-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf,
  output logic                         unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  r_ptr;   // next write slot; top lives at r_ptr-1
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_unf;
  logic [PTR_W-1:0]  w_top_idx;

  assign w_top_idx = r_ptr - PTR_W'(1);
  assign top       = r_mem[w_top_idx];
  assign count     = r_count;
  assign full      = (r_count == CNT_W'(RAS_DEPTH));
  assign empty     = (r_count == CNT_W'(0));
  assign ovf       = r_ovf;
  assign unf       = r_unf;

  // Entry storage: contents need no reset, only the pointer/count define validity.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      r_mem[r_ptr] <= push_data;
    end
  end

  // Pointer, occupancy and sticky flag bookkeeping; push and pop are never both set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (full) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (pop) begin
      if (empty) begin
        r_unf <= 1'b1;
      end else begin
        r_ptr   <= w_top_idx;
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_ras.sv
// Instruction fetch unit: PC register, absolute/relative target generation and
// prioritised next-PC select (ret > call > jmp > taken branch > increment).
module instr_fetch_ras
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEFAULT,
  parameter int                TGT_W      = TGT_W_DEFAULT,
  parameter int                RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = {ADDR_W{1'b0}}
) (
  input  logic                        CLK,
  input  logic                        reset_ctrl,
  input  logic                        stall_in,
  input  logic [TGT_W-1:0]            dst_in,
  input  logic                        rel_ctrl,
  input  logic                        br_ctrl,
  input  logic                        accdata_in,
  input  logic                        jmp_ctrl,
  input  logic                        call_ctrl,
  input  logic                        ret_ctrl,
  output logic [ADDR_W-1:0]           instr_addr,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_ovf,
  output logic                        ras_unf
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_abs_tgt;
  logic [ADDR_W-1:0] w_rel_tgt;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;
  logic              w_push;
  logic              w_pop;
  next_pc_sel_t      w_sel;

  assign w_pc_inc  = r_pc + ADDR_W'(1);
  // Absolute targets take the page of pc_inc so a page crossing on increment is kept.
  assign w_abs_tgt = {w_pc_inc[ADDR_W-1:TGT_W], dst_in};
  assign w_rel_tgt = r_pc + ADDR_W'(sext_tgt(32'(dst_in), TGT_W));
  assign w_tgt     = rel_ctrl ? w_rel_tgt : w_abs_tgt;

  // Next-PC source and stack operation; stall suppresses every stack action.
  always_comb begin
    w_sel  = SEL_INC;
    w_push = 1'b0;
    w_pop  = 1'b0;
    if (ret_ctrl) begin
      w_pop = !stall_in;
      if (w_ras_empty) begin
        w_sel = SEL_INC;
      end else begin
        w_sel = SEL_RET;
      end
    end else if (call_ctrl) begin
      w_sel  = SEL_TGT;
      w_push = !stall_in;
    end else if (jmp_ctrl) begin
      w_sel = SEL_TGT;
    end else if (br_ctrl && accdata_in) begin
      w_sel = SEL_TGT;
    end else begin
      w_sel = SEL_INC;
    end
  end

  // PC register: reset wins over stall, stall holds, otherwise load selected source.
  always_ff @(posedge CLK) begin
    if (reset_ctrl) begin
      r_pc <= RESET_ADDR;
    end else if (!stall_in) begin
      case (w_sel)
        SEL_INC: r_pc <= w_pc_inc;
        SEL_TGT: r_pc <= w_tgt;
        SEL_RET: r_pc <= w_ras_top;
        default: r_pc <= w_pc_inc;
      endcase
    end
  end

  assign instr_addr = r_pc;

  return_addr_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (reset_ctrl),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_ras_top),
    .count     (ras_count),
    .full      (),
    .empty     (w_ras_empty),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

endmodule

// File: tb/tb_instr_fetch_ras.sv
// Directed self-checking bench for instr_fetch_ras (default parameters).
module tb_instr_fetch_ras;

  logic        CLK = 1'b0;
  logic        reset_ctrl = 1'b0;
  logic        stall_in = 1'b0;
  logic [7:0]  dst_in = 8'h00;
  logic        rel_ctrl = 1'b0;
  logic        br_ctrl = 1'b0;
  logic        accdata_in = 1'b0;
  logic        jmp_ctrl = 1'b0;
  logic        call_ctrl = 1'b0;
  logic        ret_ctrl = 1'b0;
  logic [15:0] instr_addr;
  logic [2:0]  ras_count;
  logic        ras_ovf;
  logic        ras_unf;

  int total = 0;
  int bad   = 0;

  instr_fetch_ras #(
    .ADDR_W(16), .TGT_W(8), .RAS_DEPTH(4), .RESET_ADDR(16'h0000)
  ) dut (
    .CLK        (CLK),
    .reset_ctrl (reset_ctrl),
    .stall_in   (stall_in),
    .dst_in     (dst_in),
    .rel_ctrl   (rel_ctrl),
    .br_ctrl    (br_ctrl),
    .accdata_in (accdata_in),
    .jmp_ctrl   (jmp_ctrl),
    .call_ctrl  (call_ctrl),
    .ret_ctrl   (ret_ctrl),
    .instr_addr (instr_addr),
    .ras_count  (ras_count),
    .ras_ovf    (ras_ovf),
    .ras_unf    (ras_unf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset_ctrl = 1'b0; stall_in = 1'b0; rel_ctrl = 1'b0; br_ctrl = 1'b0;
    accdata_in = 1'b0; jmp_ctrl = 1'b0; call_ctrl = 1'b0; ret_ctrl = 1'b0;
  endtask

  // Apply current inputs across one rising edge, then return the inputs to idle.
  task automatic tick();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic chk_state(input string tag, input logic [15:0] pc, input logic [2:0] cnt,
                           input logic ovf, input logic unf);
    chk({tag, ".pc"},  32'(instr_addr), 32'(pc));
    chk({tag, ".cnt"}, 32'(ras_count),  32'(cnt));
    chk({tag, ".ovf"}, 32'(ras_ovf),    32'(ovf));
    chk({tag, ".unf"}, 32'(ras_unf),    32'(unf));
  endtask

  task automatic do_jmp(input logic [7:0] d, input logic rel);
    jmp_ctrl = 1'b1; dst_in = d; rel_ctrl = rel; tick();
  endtask

  task automatic do_call(input logic [7:0] d);
    call_ctrl = 1'b1; dst_in = d; tick();
  endtask

  task automatic do_ret();
    ret_ctrl = 1'b1; tick();
  endtask

  logic [15:0] ret_exp [4];

  initial begin
    idle();
    #1;
    reset_ctrl = 1'b1; tick();
    chk_state("reset", 16'h0000, 3'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("idle_pc", 32'(instr_addr), i);
    end
    chk_state("idle_end", 16'h0004, 3'd0, 1'b0, 1'b0);

    // Conditional branch taken / not taken
    br_ctrl = 1'b1; accdata_in = 1'b1; dst_in = 8'h20; tick();
    chk("br_taken", 32'(instr_addr), 32'h0020);
    do_jmp(8'h04, 1'b0);
    chk("jmp_abs", 32'(instr_addr), 32'h0004);
    br_ctrl = 1'b1; accdata_in = 1'b0; dst_in = 8'h20; tick();
    chk("br_not_taken", 32'(instr_addr), 32'h0005);

    // Relative jump and wrap
    do_jmp(8'h10, 1'b0);
    chk("jmp_to_10", 32'(instr_addr), 32'h0010);
    do_jmp(8'hFC, 1'b1);
    chk("jmp_rel_neg", 32'(instr_addr), 32'h000C);
    do_jmp(8'hF3, 1'b1);
    chk("jmp_rel_wrap", 32'(instr_addr), 32'hFFFF);
    tick();
    chk("inc_wrap", 32'(instr_addr), 32'h0000);

    // Absolute target takes the page of pc_inc
    do_jmp(8'hFF, 1'b0);
    chk("jmp_ff", 32'(instr_addr), 32'h00FF);
    do_jmp(8'h05, 1'b0);
    chk("jmp_page_cross", 32'(instr_addr), 32'h0105);

    // Branch with relative target
    br_ctrl = 1'b1; accdata_in = 1'b1; rel_ctrl = 1'b1; dst_in = 8'h7F; tick();
    chk("br_rel_pos", 32'(instr_addr), 32'h0184);

    reset_ctrl = 1'b1; tick();
    chk_state("reset2", 16'h0000, 3'd0, 1'b0, 1'b0);
    do_jmp(8'h10, 1'b0);

    // Nested calls and returns
    do_call(8'h40);
    chk_state("call1", 16'h0040, 3'd1, 1'b0, 1'b0);
    tick();
    chk("inc_41", 32'(instr_addr), 32'h0041);
    do_call(8'h80);
    chk_state("call2", 16'h0080, 3'd2, 1'b0, 1'b0);
    do_ret();
    chk_state("ret1", 16'h0042, 3'd1, 1'b0, 1'b0);
    do_ret();
    chk_state("ret2", 16'h0011, 3'd0, 1'b0, 1'b0);

    // Overflow: five calls, the return address 0x12 is lost
    do_call(8'h20);
    do_call(8'h30);
    do_call(8'h40);
    do_call(8'h50);
    chk_state("call4", 16'h0050, 3'd4, 1'b0, 1'b0);
    do_call(8'h60);
    chk_state("call5_ovf", 16'h0060, 3'd4, 1'b1, 1'b0);
    ret_exp[0] = 16'h0051; ret_exp[1] = 16'h0041;
    ret_exp[2] = 16'h0031; ret_exp[3] = 16'h0021;
    for (int i = 0; i < 4; i++) begin
      do_ret();
      chk("ret_lifo_pc", 32'(instr_addr), 32'(ret_exp[i]));
      chk("ret_lifo_cnt", 32'(ras_count), 32'(3 - i));
    end
    do_ret();
    chk_state("ret_unf", 16'h0022, 3'd0, 1'b1, 1'b1);

    // call+ret together: ret wins, nothing pushed
    call_ctrl = 1'b1; ret_ctrl = 1'b1; dst_in = 8'h77; tick();
    chk_state("call_ret", 16'h0023, 3'd0, 1'b1, 1'b1);

    // Stall with a non-empty stack: nothing moves
    do_call(8'h90);
    chk_state("pre_stall", 16'h0090, 3'd1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stall_in = 1'b1; call_ctrl = 1'b1; dst_in = 8'h55; tick();
      chk_state("stall_call", 16'h0090, 3'd1, 1'b1, 1'b1);
    end
    stall_in = 1'b1; ret_ctrl = 1'b1; tick();
    chk_state("stall_ret", 16'h0090, 3'd1, 1'b1, 1'b1);
    do_ret();
    chk("ret_after_stall", 32'(instr_addr), 32'h0024);

    // Reset together with stall
    stall_in = 1'b1; reset_ctrl = 1'b1; call_ctrl = 1'b1; tick();
    chk_state("reset_stall", 16'h0000, 3'd0, 1'b0, 1'b0);

    // Reset together with call performs reset only
    do_jmp(8'h33, 1'b0);
    reset_ctrl = 1'b1; call_ctrl = 1'b1; dst_in = 8'h44; tick();
    chk_state("reset_call", 16'h0000, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ras.md
Name: instr_fetch_ras

Overview:
Parametrised next-generation instruction fetch unit. It holds the program counter and selects the next PC from these sources:
- sequential increment
- conditional branch (btr)
- unconditional jump
- call/return through a small hardware return-address stack (RAS)

It adds a stall input and PC-relative targeting. It sits between the control decoder and instruction memory, driving instr_addr every cycle.

Parameters:
ADDR_W, 16, width of the PC and instr_addr.
TGT_W, 8, width of dst_in target operand; must be < ADDR_W.
RAS_DEPTH, 4, number of return-address entries; power of two, >= 2.
RESET_ADDR, 0, PC value loaded on reset.

Ports:
CLK  input  1  clock; all state updates on rising edge.
reset_ctrl  input  1  synchronous, active-high reset.
stall_in  input  1  high: hold PC and RAS, ignore all controls this cycle.
dst_in  input  TGT_W  branch/jump/call target operand from $dst.
rel_ctrl  input  1  0: absolute target {pc_inc[ADDR_W-1:TGT_W], dst_in}; 1: PC-relative target pc + sign_extend(dst_in).
br_ctrl  input  1  conditional branch; taken when accdata_in = 1.
accdata_in  input  1  accumulator condition bit.
jmp_ctrl  input  1  unconditional jump to target.
call_ctrl  input  1  jump to target and push pc_inc onto the RAS.
ret_ctrl  input  1  pop the RAS and jump to the popped address.
instr_addr  output  ADDR_W  current PC.
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
ras_ovf  output  1  sticky: a push occurred while full.
ras_unf  output  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (synchronous, wins over everything incl. stall_in):
  - instr_addr <= RESET_ADDR; ras_count <= 0; ras_ovf <= 0; ras_unf <= 0.
  - RAS entry contents are don't-care.
- pc_inc = instr_addr + 1, modulo 2^ADDR_W (wraps from all-ones to 0).
- Target arithmetic:
  - Relative target = instr_addr + sign-extended dst_in, modulo 2^ADDR_W.
  - Absolute target keeps the upper bits of pc_inc, so a page crossing at increment is honoured.
- Next-PC priority, evaluated when stall_in = 0 (one source per cycle):
  1. ret_ctrl = 1:
     - RAS non-empty: PC <= top entry; pop.
     - RAS empty: PC <= pc_inc; set ras_unf; count stays 0.
  2. call_ctrl = 1: PC <= target; push pc_inc.
  3. jmp_ctrl = 1: PC <= target.
  4. br_ctrl = 1 and accdata_in = 1: PC <= target.
  5. Otherwise: PC <= pc_inc.
- A lower-priority control asserted together with a higher one has no effect (e.g. call+ret = ret only; nothing is pushed).
- RAS push when full (count = RAS_DEPTH):
  - Circular overwrite: the oldest entry is discarded and the new entry becomes top.
  - Count stays RAS_DEPTH; ras_ovf is set.
- Stall: stall_in = 1 holds instr_addr, RAS contents, count and flags unchanged regardless of other controls.
- Latency: controls sampled at edge N affect instr_addr after edge N; instr_addr is registered (no combinational path from inputs to instr_addr).
- ras_ovf/ras_unf clear only on reset.
- Reset asserted mid-sequence (e.g. with call_ctrl) performs reset only; no push.

Decomposition:
- Package fetch_pkg:
  - Enum next_pc_sel_t {SEL_INC, SEL_TGT, SEL_RET}.
  - Function sext_tgt for target sign extension.
  - Constants ADDR_W_DEFAULT, TGT_W_DEFAULT.
- Sub-module return_addr_stack:
  - Circular-buffer stack with push, pop, top, count, full, empty, ovf and unf outputs.
  - Parametrised by ADDR_W and RAS_DEPTH.
- Top level holds the PC register, target computation and priority select.

Test Plan:
- Reset then 4 idle cycles -> instr_addr 0,1,2,3,4; ras_count 0; flags 0.
- At PC=4: br_ctrl=1, accdata_in=1, dst_in=8'h20, rel_ctrl=0 -> next PC 0x0020. Repeat with accdata_in=0 -> next PC 5.
- At PC=0x0010: rel_ctrl=1, jmp_ctrl=1, dst_in=8'hFC -> next PC 0x000C. At PC=0xFFFF with no control -> next PC 0x0000.
- Nested calls (RAS_DEPTH=4):
  - At PC=0x10, call dst_in=0x40 -> PC 0x40, ras_count 1.
  - At PC=0x41, call dst_in=0x80 -> PC 0x80, ras_count 2.
  - ret -> PC 0x42; ret -> PC 0x11; ras_count 0; no flags.
- Five calls without returns -> ras_count stays 4 and ras_ovf=1. Five rets -> first four return in LIFO order (the oldest return address is lost); the fifth yields PC=pc_inc and sets ras_unf=1.
- Hold stall_in=1 with call_ctrl=1 for 3 cycles -> instr_addr and ras_count unchanged. Then assert reset_ctrl together with stall_in=1 -> instr_addr=RESET_ADDR, ras_count=0, flags cleared next cycle.
